mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-port arbiter sharing the single Memory bus between the CPU (port 0) and a second
//  bus master such as a loader/DMA (port 1). Sits between the requesters and Memory and
//  owns mem_read/mem_write/mem_address_bus/data_to_mem. Each access is a req/ack handshake.
//  Ties are resolved round-robin; the bus is held for a fixed number of cycles per access.
// PARAMETERS
//  WORD_SIZE      16  data word width (INST_SIZE+REG_ADDR_SIZE+MEM_ADDR_SIZE)
//  MEM_ADDR_SIZE   6  memory address width
//  ACCESS_CYCLES   2  cycles strobe is held per access; legal range >=1
// PORTS
//  clock            in   1   system clock, rising edge
//  reset            in   1   asynchronous, active-low reset
//  req0/req1        in   1   access request, port 0 / port 1
//  we0/we1          in   1   1=write, 0=read; valid while reqN high
//  addr0/addr1      in   MEM_ADDR_SIZE  access address; valid while reqN high
//  wdata0/wdata1    in   WORD_SIZE      write data; valid while reqN high
//  ack0/ack1        out  1   one-cycle completion pulse
//  rdata0/rdata1    out  WORD_SIZE      read result, held until next read on that port
//  mem_read         out  1   memory read strobe
//  mem_write        out  1   memory write strobe
//  mem_address_bus  out  MEM_ADDR_SIZE  memory address
//  data_to_mem      out  WORD_SIZE      memory write data
//  data_from_mem    in   WORD_SIZE      memory read data (combinational from Memory)
//  busy             out  1   high in ACCESS and DONE
//  owner            out  1   port currently granted; valid when busy
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs 0; last_grant=1 (port 0 wins first tie).
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs registered.
//  IDLE: at an edge with any reqN=1: winner = sole requester, else the port != last_grant.
//   Latch winner's addr/we/wdata; owner<=winner; last_grant<=winner; cnt<=ACCESS_CYCLES-1;
//   mem_read<=~we, mem_write<=we, mem_address_bus<=addr, data_to_mem<=(we?wdata:0); ->ACCESS.
//  ACCESS: bus outputs stable. If cnt!=0: cnt<=cnt-1. If cnt==0: if read,
//   rdata[owner]<=data_from_mem; ack[owner]<=1; mem_read,mem_write<=0; ->DONE.
//  DONE: ack high this one cycle; at next edge ack<=0, ->IDLE. req not sampled in DONE.
//  Strobe high exactly ACCESS_CYCLES cycles; req-sample edge to ack-rise = ACCESS_CYCLES edges;
//   min issue spacing per port = ACCESS_CYCLES+2 cycles.
//  Requester drops reqN during the ack cycle; reqN still high in IDLE = new request (back-to-back).
//  Inputs changing after the latch edge are ignored for the current access.
//  Both ports continuously requesting -> strict alternation 0,1,0,1,...
//  Writes never alter rdataN; mem_address_bus/data_to_mem hold last values in IDLE/DONE.
//  Only one of mem_read/mem_write high at any time; ack0 and ack1 never both high.
//  Reset asserted mid-ACCESS/DONE: access aborted, no ack, outputs 0 immediately.
// TESTING
//  1 Mem[05]=BEEF, port0 read 05 -> mem_read high 2 cycles, addr 05, ack0 1 cycle, rdata0=BEEF.
//  2 Port1 write 3F<=A5A5, then port1 read 3F -> mem_write 2 cycles w/ A5A5; rdata1=A5A5.
//  3 req0,req1 rise same edge after reset, held -> grants 0,1,0,1 over 4 accesses, no overlap.
//  4 reset low during ACCESS -> strobes, busy to 0 at once, no ack; after release tie -> port0.
//  5 ACCESS_CYCLES=1, port0 read -> strobe 1 cycle, ack0 rises 1 edge after req sampled.
//  6 rdata0=1234, port0 write 10<=FFFF -> rdata0 stays 1234, ack0 pulses once.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter that owns the shared memory bus. Each access is a
// req/ack handshake holding the strobe for ACCESS_CYCLES cycles, then a one-cycle ack.
module mem_bus_arbiter #(
    parameter int WORD_SIZE     = 16,
    parameter int MEM_ADDR_SIZE = 6,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [MEM_ADDR_SIZE-1:0] addr0,
    input  logic [MEM_ADDR_SIZE-1:0] addr1,
    input  logic [WORD_SIZE-1:0]     wdata0,
    input  logic [WORD_SIZE-1:0]     wdata1,
    output logic                     ack0,
    output logic                     ack1,
    output logic [WORD_SIZE-1:0]     rdata0,
    output logic [WORD_SIZE-1:0]     rdata1,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [MEM_ADDR_SIZE-1:0] mem_address_bus,
    output logic [WORD_SIZE-1:0]     data_to_mem,
    input  logic [WORD_SIZE-1:0]     data_from_mem,
    output logic                     busy,
    output logic                     owner
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam int               CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

    logic [1:0]               state;
    logic [CNT_W-1:0]         cnt;
    logic                     last_grant;
    logic                     access_we;

    logic                     winner;
    logic                     win_we;
    logic [MEM_ADDR_SIZE-1:0] win_addr;
    logic [WORD_SIZE-1:0]     win_wdata;

    // On a tie the port that did not win last time is served.
    assign winner    = (req0 && req1) ? ~last_grant : req1;
    assign win_we    = winner ? we1    : we0;
    assign win_addr  = winner ? addr1  : addr0;
    assign win_wdata = winner ? wdata1 : wdata0;

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            last_grant      <= 1'b1;
            access_we       <= 1'b0;
            owner           <= 1'b0;
            busy            <= 1'b0;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            rdata0          <= '0;
            rdata1          <= '0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_address_bus <= '0;
            data_to_mem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner           <= winner;
                        last_grant      <= winner;
                        cnt             <= CNT_INIT;
                        busy            <= 1'b1;
                        access_we       <= win_we;
                        mem_read        <= ~win_we;
                        mem_write       <= win_we;
                        mem_address_bus <= win_addr;
                        data_to_mem     <= win_we ? win_wdata : '0;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        if (!access_we) begin
                            if (owner) rdata1 <= data_from_mem;
                            else       rdata0 <= data_from_mem;
                        end
                        if (owner) ack1 <= 1'b1;
                        else       ack0 <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Requests are not sampled here; a still-high req is taken in IDLE.
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    strobe_exclusive: assert property (@(posedge clock) disable iff (!reset)
        !(mem_read && mem_write));
    ack_exclusive: assert property (@(posedge clock) disable iff (!reset)
        !(ack0 && ack1));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model with a reference memory image.
module tb_mem_bus_arbiter;

    localparam int WS = 16;
    localparam int AW = 6;
    localparam int AC = 2;
    localparam logic [27:0] OWNER_MASK = ~(28'h1 << 26);

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [WS-1:0] wdata0, wdata1;
    logic          ack0, ack1, mem_read, mem_write, busy, owner;
    logic [WS-1:0] rdata0, rdata1, data_to_mem, data_from_mem;
    logic [AW-1:0] mem_address_bus;

    // Second instance with single-cycle accesses; only port 0 is exercised.
    logic          req0_b, req1_b, we0_b, we1_b;
    logic [AW-1:0] addr0_b, addr1_b;
    logic [WS-1:0] wdata0_b, wdata1_b;
    logic          ack0_b, ack1_b, mem_read_b, mem_write_b, busy_b, owner_b;
    logic [WS-1:0] rdata0_b, rdata1_b, data_to_mem_b, data_from_mem_b;
    logic [AW-1:0] mem_address_bus_b;

    mem_bus_arbiter #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AW), .ACCESS_CYCLES(AC)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address_bus(mem_address_bus), .data_to_mem(data_to_mem),
        .data_from_mem(data_from_mem), .busy(busy), .owner(owner)
    );

    mem_bus_arbiter #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AW), .ACCESS_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset),
        .req0(req0_b), .req1(req1_b), .we0(we0_b), .we1(we1_b),
        .addr0(addr0_b), .addr1(addr1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .ack0(ack0_b), .ack1(ack1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b),
        .mem_address_bus(mem_address_bus_b), .data_to_mem(data_to_mem_b),
        .data_from_mem(data_from_mem_b), .busy(busy_b), .owner(owner_b)
    );

    // Memory environment: combinational read, clocked write, preload port.
    logic [WS-1:0] mem [64];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [WS-1:0] pre_data;
    always @(posedge clock) begin
        if (pre_we)         mem[pre_addr] <= pre_data;
        else if (mem_write) mem[mem_address_bus] <= data_to_mem;
    end
    assign data_from_mem   = mem[mem_address_bus];
    assign data_from_mem_b = {10'h0, mem_address_bus_b} ^ 16'h5A5A;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    logic [WS-1:0] ref_mem [64];
    logic [WS-1:0] exp_rd [2];
    bit            last_m;
    bit            pend [2];
    bit            p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [WS-1:0] p_wdata [2];

    function automatic logic [27:0] bus_obs();
        return {busy, owner, mem_read, mem_write, ack0, ack1, mem_address_bus, data_to_mem};
    endfunction

    function automatic logic [27:0] bus_obs_b();
        return {busy_b, owner_b, mem_read_b, mem_write_b, ack0_b, ack1_b,
                mem_address_bus_b, data_to_mem_b};
    endfunction

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_m = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [WS-1:0] d);
        pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
    endtask

    task automatic drive_inputs();
        req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdata[0];
        req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdata[1];
    endtask

    // One arbitration round, starting and ending 1 time unit after a rising edge in IDLE.
    task automatic run_round(input string tag);
        int            w;
        bit            we;
        logic [AW-1:0] a;
        logic [WS-1:0] dtm;
        logic [27:0]   e_acc, e_ack, e_idle;
        if (!pend[0] && !pend[1]) begin
            @(posedge clock); #1;
            return;
        end
        drive_inputs();
        w   = (pend[0] && pend[1]) ? (last_m ? 0 : 1) : (pend[0] ? 0 : 1);
        we  = p_we[w];
        a   = p_addr[w];
        dtm = we ? p_wdata[w] : '0;
        e_acc  = {1'b1, w[0], !we, we, 2'b00, a, dtm};
        e_ack  = {1'b1, w[0], 2'b00, w == 0, w == 1, a, dtm};
        e_idle = {1'b0, 1'b0, 2'b00, 2'b00, a, dtm};

        @(posedge clock); #1;
        vectors++;
        if (bus_obs() !== e_acc) begin
            miscompares++;
            $display("FAIL %s grant: got %h expected %h", tag, bus_obs(), e_acc);
        end
        if (w == 0) begin
            we0 = 1'($urandom); addr0 = 6'($urandom); wdata0 = 16'($urandom);
        end else begin
            we1 = 1'($urandom); addr1 = 6'($urandom); wdata1 = 16'($urandom);
        end
        repeat (AC - 1) begin
            @(posedge clock); #1;
            vectors++;
            if (bus_obs() !== e_acc) begin
                miscompares++;
                $display("FAIL %s hold: got %h expected %h", tag, bus_obs(), e_acc);
            end
        end

        if (we) ref_mem[a] = dtm;
        else    exp_rd[w]  = ref_mem[a];
        @(posedge clock); #1;
        vectors++;
        if (bus_obs() !== e_ack) begin
            miscompares++;
            $display("FAIL %s ack: got %h expected %h", tag, bus_obs(), e_ack);
        end
        vectors++;
        if ({rdata0, rdata1} !== {exp_rd[0], exp_rd[1]}) begin
            miscompares++;
            $display("FAIL %s rdata: got %h/%h expected %h/%h", tag, rdata0, rdata1,
                     exp_rd[0], exp_rd[1]);
        end
        pend[w] = 1'b0;
        last_m  = w[0];
        drive_inputs();

        @(posedge clock); #1;
        vectors++;
        if ((bus_obs() & OWNER_MASK) !== e_idle) begin
            miscompares++;
            $display("FAIL %s done: got %h expected %h", tag, bus_obs() & OWNER_MASK, e_idle);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        p_we[0] = 1'b0; p_we[1] = 1'b0;
        p_addr[0] = '0; p_addr[1] = '0;
        p_wdata[0] = '0; p_wdata[1] = '0;
        drive_inputs();
        req0_b = 1'b0; req1_b = 1'b0; we0_b = 1'b0; we1_b = 1'b0;
        addr0_b = '0; addr1_b = '0; wdata0_b = '0; wdata1_b = '0;
        pre_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pre_addr = 6'(i);
            pre_data = (i == 5) ? 16'hBEEF : 16'($urandom);
            ref_mem[i] = pre_data;
            @(posedge clock); #1;
        end
        pre_we = 1'b0;
        model_reset();
        vectors++;
        if ({bus_obs(), rdata0, rdata1} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h/%h/%h expected 0", bus_obs(), rdata0, rdata1);
        end
        vectors++;
        if ({bus_obs_b(), rdata0_b, rdata1_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_state_b: got %h expected 0", bus_obs_b());
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({bus_obs(), rdata0, rdata1} !== '0) begin
            miscompares++;
            $display("FAIL idle_no_req: got %h expected 0", bus_obs());
        end
    endtask

    task automatic test_read();
        issue(0, 1'b0, 6'h05, 16'h0);
        run_round("read05");
        vectors++;
        if (rdata0 !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL read05_value: got %h expected beef", rdata0);
        end
    endtask

    task automatic test_write_read();
        issue(1, 1'b1, 6'h3F, 16'hA5A5);
        run_round("write3f");
        issue(1, 1'b0, 6'h3F, 16'h0);
        run_round("read3f");
        vectors++;
        if (rdata1 !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL read3f_value: got %h expected a5a5", rdata1);
        end
    endtask

    task automatic test_tie_alternation();
        reset = 1'b0;
        model_reset();
        drive_inputs();
        @(posedge clock); #1;
        reset = 1'b1;
        issue(0, 1'b0, 6'h01, 16'h0);
        issue(1, 1'b0, 6'h02, 16'h0);
        for (int k = 0; k < 4; k++) begin
            run_round("tie");
            if (!pend[0]) issue(0, 1'b0, 6'(k + 3), 16'h0);
            if (!pend[1]) issue(1, 1'b0, 6'(k + 9), 16'h0);
        end
        model_reset();
        drive_inputs();
    endtask

    task automatic test_reset_mid_access();
        issue(1, 1'b1, 6'h2A, 16'h7777);
        drive_inputs();
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus_obs(), rdata0, rdata1} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_access: got %h expected 0", bus_obs());
        end
        model_reset();
        drive_inputs();
        @(posedge clock); #1;
        vectors++;
        if ({ack0, ack1} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_no_ack: got %b expected 00", {ack0, ack1});
        end
        reset = 1'b1;
        issue(0, 1'b0, 6'h2A, 16'h0);
        issue(1, 1'b0, 6'h2A, 16'h0);
        run_round("post_reset_tie");
        run_round("post_reset_tie");
    endtask

    task automatic test_access_cycles_1();
        logic [27:0] e;
        req0_b = 1'b1; we0_b = 1'b0; addr0_b = 6'h21;
        @(posedge clock); #1;
        e = {1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'h21, 16'h0};
        vectors++;
        if (bus_obs_b() !== e) begin
            miscompares++;
            $display("FAIL ac1_strobe: got %h expected %h", bus_obs_b(), e);
        end
        @(posedge clock); #1;
        e = {1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 6'h21, 16'h0};
        vectors++;
        if (bus_obs_b() !== e || rdata0_b !== (16'h0021 ^ 16'h5A5A) || rdata1_b !== '0) begin
            miscompares++;
            $display("FAIL ac1_ack: got %h rdata %h/%h expected %h rdata %h/0000",
                     bus_obs_b(), rdata0_b, rdata1_b, e, 16'h0021 ^ 16'h5A5A);
        end
        req0_b = 1'b0;
        @(posedge clock); #1;
        e = {1'b0, 1'b0, 2'b00, 2'b00, 6'h21, 16'h0};
        vectors++;
        if ((bus_obs_b() & OWNER_MASK) !== e) begin
            miscompares++;
            $display("FAIL ac1_done: got %h expected %h", bus_obs_b() & OWNER_MASK, e);
        end
    endtask

    task automatic test_write_keeps_rdata();
        issue(0, 1'b1, 6'h11, 16'h1234);
        run_round("w11");
        issue(0, 1'b0, 6'h11, 16'h0);
        run_round("r11");
        issue(0, 1'b1, 6'h10, 16'hFFFF);
        run_round("w10");
        vectors++;
        if (rdata0 !== 16'h1234) begin
            miscompares++;
            $display("FAIL write_keeps_rdata: got %h expected 1234", rdata0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0)
                    issue(p, 1'($urandom), 6'($urandom), 16'($urandom));
            end
            run_round("random");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_tie_alternation();
        test_reset_mid_access();
        test_access_cycles_1();
        test_write_keeps_rdata();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
